// File: rtl/seg7_display_scheduler_pkg.sv
// Shared types and constants for the 4-digit 7-segment display scheduler.
// Digit patterns are gfedcba, active-high; anode bit 3 is the leftmost digit.
package seg7_pkg;

    localparam logic [3:0] AN_DK1    = 4'b1000;
    localparam logic [3:0] AN_DK2    = 4'b0100;
    localparam logic [3:0] AN_DK3    = 4'b0010;
    localparam logic [3:0] AN_DK4    = 4'b0001;
    localparam logic [3:0] AN_OFF    = 4'b0000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        SPEED = 1'b0,
        KEY   = 1'b1
    } state_e;

    typedef logic [6:0] digit_t;

    // dk1 is the leftmost digit
    typedef struct packed {
        digit_t dk1;
        digit_t dk2;
        digit_t dk3;
        digit_t dk4;
    } frame_t;

    function automatic digit_t frame_digit(frame_t f, logic [1:0] idx);
        case (idx)
            2'd0:    return f.dk1;
            2'd1:    return f.dk2;
            2'd2:    return f.dk3;
            default: return f.dk4;
        endcase
    endfunction

    function automatic logic [3:0] an_for_idx(logic [1:0] idx);
        case (idx)
            2'd0:    return AN_DK1;
            2'd1:    return AN_DK2;
            2'd2:    return AN_DK3;
            default: return AN_DK4;
        endcase
    endfunction

endpackage

// File: rtl/seg7_display_scheduler_if.sv
// Pattern sources in, display pins out. key_valid is a one-cycle strobe with no
// ready: the scheduler accepts every strobe in the cycle it is asserted.
interface seg7_display_scheduler_if;
    import seg7_pkg::*;

    logic       disp_en;
    logic       key_valid;
    logic [6:0] key_dk1;
    logic [6:0] key_dk2;
    logic [6:0] key_dk3;
    logic [6:0] key_dk4;
    logic [6:0] spd_dk1;
    logic [6:0] spd_dk2;
    logic [6:0] spd_dk3;
    logic [6:0] spd_dk4;
    logic [6:0] seg;
    logic [3:0] an;
    logic       src_key;
    state_e     state_dbg;

    modport master (
        output disp_en, key_valid, key_dk1, key_dk2, key_dk3, key_dk4,
        output spd_dk1, spd_dk2, spd_dk3, spd_dk4,
        input  seg, an, src_key, state_dbg
    );

    modport slave (
        input  disp_en, key_valid, key_dk1, key_dk2, key_dk3, key_dk4,
        input  spd_dk1, spd_dk2, spd_dk3, spd_dk4,
        output seg, an, src_key, state_dbg
    );

endinterface

// File: rtl/seg7_scan_mux.sv
// Resettable digit scan: picks the current digit of the selected frame and
// registers seg/an together so both pins always change on the same edge.
module seg7_scan_mux
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       disp_en,
    input  logic       sel_key,
    input  frame_t     key_frame,
    input  frame_t     spd_frame,
    output logic [6:0] seg,
    output logic [3:0] an
);

    logic [1:0] idx_q, idx_d;
    logic [6:0] seg_q, seg_d;
    logic [3:0] an_q, an_d;
    frame_t     frame_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 2'd0;
            seg_q <= SEG_BLANK;
            an_q  <= AN_OFF;
        end else begin
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    // The scan keeps running while blanked so the phase survives a disable.
    always_comb begin
        idx_d     = idx_q + 2'd1;
        frame_sel = sel_key ? key_frame : spd_frame;
        seg_d     = SEG_BLANK;
        an_d      = AN_OFF;
        if (disp_en) begin
            seg_d = frame_digit(frame_sel, idx_q);
            an_d  = an_for_idx(idx_q);
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: rtl/seg7_display_scheduler.sv
// Chooses between the latched key message and the live speed frame, holding a
// key message for HOLD_MS display-clock cycles after its last strobe.
module seg7_display_scheduler
    import seg7_pkg::*;
#(
    parameter int unsigned HOLD_MS = 2000
) (
    input  logic                      clk_1khz,
    input  logic                      rst,
    seg7_display_scheduler_if.slave   bus
);

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_MS - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    frame_t      key_q, key_d;
    logic        src_key_q, src_key_d;
    logic        sel_key;
    frame_t      spd_frame;

    assign spd_frame = '{dk1: bus.spd_dk1, dk2: bus.spd_dk2,
                         dk3: bus.spd_dk3, dk4: bus.spd_dk4};

    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            state_q   <= SPEED;
            cnt_q     <= 16'd0;
            key_q     <= '0;
            src_key_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            src_key_q <= src_key_d;
        end
    end

    // A strobe always wins, including on the cycle the hold would expire.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        if (bus.key_valid) begin
            state_d = KEY;
            cnt_d   = HOLD_LOAD;
            key_d   = '{dk1: bus.key_dk1, dk2: bus.key_dk2,
                        dk3: bus.key_dk3, dk4: bus.key_dk4};
        end else if (state_q == KEY) begin
            if (cnt_q != 16'd0) begin
                cnt_d = cnt_q - 16'd1;
            end else begin
                state_d = SPEED;
            end
        end
    end

    // src_key is registered alongside seg/an so it lines up with the first digit.
    always_comb begin
        sel_key   = (state_q == KEY);
        src_key_d = sel_key;
    end

    seg7_scan_mux u_scan (
        .clk       (clk_1khz),
        .rst       (rst),
        .disp_en   (bus.disp_en),
        .sel_key   (sel_key),
        .key_frame (key_q),
        .spd_frame (spd_frame),
        .seg       (bus.seg),
        .an        (bus.an)
    );

    assign bus.src_key   = src_key_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_seg7_display_scheduler.sv
// Directed bench for seg7_display_scheduler with HOLD_MS = 8.
module tb_seg7_display_scheduler;
    import seg7_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   edge_n = 0;

    always #5 clk = ~clk;

    seg7_display_scheduler_if bus();

    seg7_display_scheduler #(.HOLD_MS(8)) dut (
        .clk_1khz (clk),
        .rst      (rst),
        .bus      (bus)
    );

    // Hand-written scan order and character patterns
    logic [3:0] an_tab [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    frame_t spd_a = '{dk1: 7'h00, dk2: 7'h06, dk3: 7'h5B, dk4: 7'h3F};
    frame_t spd_b = '{dk1: 7'h66, dk2: 7'h6D, dk3: 7'h7D, dk4: 7'h07};
    frame_t fast  = '{dk1: 7'b1110001, dk2: 7'h77, dk3: 7'h6D, dk4: 7'h78};
    frame_t chup  = '{dk1: 7'b0111001, dk2: 7'h74, dk3: 7'h3E, dk4: 7'h73};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) edge_n = 0;
        else     edge_n++;
    endtask

    function automatic logic [6:0] slot_digit(frame_t f, int slot);
        case (slot)
            0:       return f.dk1;
            1:       return f.dk2;
            2:       return f.dk3;
            default: return f.dk4;
        endcase
    endfunction

    task automatic set_spd(input frame_t f);
        bus.spd_dk1 = f.dk1;
        bus.spd_dk2 = f.dk2;
        bus.spd_dk3 = f.dk3;
        bus.spd_dk4 = f.dk4;
    endtask

    // One edge, then seg/an/src_key against the frame that should be on show.
    task automatic step_check(input string tag, input bit exp_src, input frame_t f);
        int slot;
        tick();
        slot = (edge_n - 1) % 4;
        check({tag, "_src"}, 32'(bus.src_key), 32'(exp_src));
        check({tag, "_an"},  32'(bus.an),  bus.disp_en ? 32'(an_tab[slot]) : 32'd0);
        check({tag, "_seg"}, 32'(bus.seg), bus.disp_en ? 32'(slot_digit(f, slot)) : 32'd0);
    endtask

    task automatic send_key(input frame_t f, input bit exp_src, input frame_t exp_f);
        bus.key_valid = 1'b1;
        bus.key_dk1 = f.dk1;
        bus.key_dk2 = f.dk2;
        bus.key_dk3 = f.dk3;
        bus.key_dk4 = f.dk4;
        step_check("strobe", exp_src, exp_f);
        check("strobe_state", 32'(bus.state_dbg), 32'(KEY));
        bus.key_valid = 1'b0;
        bus.key_dk1 = 7'h7F;
        bus.key_dk2 = 7'h7F;
        bus.key_dk3 = 7'h7F;
        bus.key_dk4 = 7'h7F;
    endtask

    initial begin
        bus.disp_en   = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_dk1 = 7'h7F;
        bus.key_dk2 = 7'h7F;
        bus.key_dk3 = 7'h7F;
        bus.key_dk4 = 7'h7F;
        set_spd(spd_a);

        // Reset values
        tick();
        tick();
        check("rst_seg", 32'(bus.seg), 32'd0);
        check("rst_an",  32'(bus.an),  32'd0);
        check("rst_src", 32'(bus.src_key), 32'd0);
        check("rst_state", 32'(bus.state_dbg), 32'(SPEED));
        rst = 1'b0;

        // Speed scan, then a live speed change
        for (int k = 0; k < 8; k++) step_check("spd_a", 1'b0, spd_a);
        set_spd(spd_b);
        for (int k = 0; k < 4; k++) step_check("spd_b", 1'b0, spd_b);
        set_spd(spd_a);
        for (int k = 0; k < 2; k++) step_check("spd_a2", 1'b0, spd_a);

        // Single FASt message held for 8 cycles
        send_key(fast, 1'b0, spd_a);
        for (int k = 1; k <= 10; k++) step_check("fast_hold", k <= 8, (k <= 8) ? fast : spd_a);

        // ChUP five cycles after FASt restarts the hold
        send_key(fast, 1'b0, spd_a);
        for (int k = 1; k <= 4; k++) step_check("restart_a", 1'b1, fast);
        send_key(chup, 1'b1, fast);
        for (int k = 1; k <= 10; k++) step_check("restart_b", k <= 8, (k <= 8) ? chup : spd_a);

        // Strobe on the counter-zero cycle: no speed gap
        send_key(fast, 1'b0, spd_a);
        for (int k = 1; k <= 7; k++) step_check("zero_a", 1'b1, fast);
        send_key(chup, 1'b1, fast);
        for (int k = 1; k <= 10; k++) step_check("zero_b", k <= 8, (k <= 8) ? chup : spd_a);

        // Blank for 6 cycles inside a hold
        send_key(fast, 1'b0, spd_a);
        step_check("blank_pre", 1'b1, fast);
        bus.disp_en = 1'b0;
        for (int k = 2; k <= 7; k++) step_check("blank", 1'b1, fast);
        bus.disp_en = 1'b1;
        step_check("blank_post", 1'b1, fast);
        for (int k = 9; k <= 10; k++) step_check("blank_exp", 1'b0, spd_a);

        // Reset in the middle of a hold
        send_key(chup, 1'b0, spd_a);
        step_check("mid_a", 1'b1, chup);
        step_check("mid_b", 1'b1, chup);
        rst = 1'b1;
        tick();
        check("mid_rst_seg", 32'(bus.seg), 32'd0);
        check("mid_rst_an",  32'(bus.an),  32'd0);
        check("mid_rst_src", 32'(bus.src_key), 32'd0);
        check("mid_rst_state", 32'(bus.state_dbg), 32'(SPEED));
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) step_check("post_rst", 1'b0, spd_a);
        check("post_rst_state", 32'(bus.state_dbg), 32'(SPEED));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
